// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the memory arbiter
//   state_t          : arbiter FSM states
//   ID_I/ID_D/ID_L   : requester identifiers (fetch, data, loader)
//   DEFAULT_TIMEOUT  : default ACCESS cycle limit before abort
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam logic [1:0] ID_I = 2'd0;
    localparam logic [1:0] ID_D = 2'd1;
    localparam logic [1:0] ID_L = 2'd2;

    localparam int DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - combinational winner selection
//   i_req, d_req, l_req : requests from fetch, data and loader ports
//   rr_favor_d          : round-robin bit, 1 = D wins an I/D tie
//   valid               : at least one request present
//   id                  : winning requester ID
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic       i_req,
    input  logic       d_req,
    input  logic       l_req,
    input  logic       rr_favor_d,
    output logic       valid,
    output logic [1:0] id
);

    always_comb begin
        valid = i_req | d_req | l_req;
        id    = ID_I;
        if (l_req) begin
            id = ID_L;
        end else if (i_req && d_req) begin
            id = rr_favor_d ? ID_D : ID_I;
        end else if (d_req) begin
            id = ID_D;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - three-port arbiter onto one shared memory port
//   clk, reset                      : clock, synchronous active-high reset
//   i_req/i_addr -> i_rdata/i_ack   : instruction fetch read port
//   d_req/d_addr/d_wdata/d_we ->
//     d_rdata/d_ack                 : data port (d_we == 0 is a read)
//   l_req/l_addr/l_wdata/l_we->l_ack: program loader write port
//   mem_req/addr/wdata/we           : registered shared memory request
//   mem_rdata/mem_ready             : memory read data and done strobe
//   bus_err                         : one-cycle pulse with ack on timeout
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_ack,
    input  logic        d_req,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_we,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    input  logic        l_req,
    input  logic [31:0] l_addr,
    input  logic [31:0] l_wdata,
    input  logic [3:0]  l_we,
    output logic        l_ack,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_we,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        bus_err
);

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t      state, state_nxt;
    logic [1:0]  winner, winner_nxt;
    logic        rr_favor_d, rr_nxt;
    logic [7:0]  cnt, cnt_nxt;
    logic        mem_req_nxt;
    logic [31:0] addr_nxt, wdata_nxt;
    logic [3:0]  we_nxt;
    logic [31:0] i_rdata_nxt, d_rdata_nxt;
    logic        i_ack_nxt, d_ack_nxt, l_ack_nxt, bus_err_nxt;

    logic        pick_valid;
    logic [1:0]  pick_id;

    mem_arb_pick u_pick (
        .i_req      (i_req),
        .d_req      (d_req),
        .l_req      (l_req),
        .rr_favor_d (rr_favor_d),
        .valid      (pick_valid),
        .id         (pick_id)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            winner     <= ID_I;
            rr_favor_d <= 1'b0;
            cnt        <= 8'd0;
            mem_req    <= 1'b0;
            mem_addr   <= 32'd0;
            mem_wdata  <= 32'd0;
            mem_we     <= 4'd0;
            i_rdata    <= 32'd0;
            d_rdata    <= 32'd0;
            i_ack      <= 1'b0;
            d_ack      <= 1'b0;
            l_ack      <= 1'b0;
            bus_err    <= 1'b0;
        end else begin
            state      <= state_nxt;
            winner     <= winner_nxt;
            rr_favor_d <= rr_nxt;
            cnt        <= cnt_nxt;
            mem_req    <= mem_req_nxt;
            mem_addr   <= addr_nxt;
            mem_wdata  <= wdata_nxt;
            mem_we     <= we_nxt;
            i_rdata    <= i_rdata_nxt;
            d_rdata    <= d_rdata_nxt;
            i_ack      <= i_ack_nxt;
            d_ack      <= d_ack_nxt;
            l_ack      <= l_ack_nxt;
            bus_err    <= bus_err_nxt;
        end
    end

    // Acks and bus_err are registered on the ACCESS->RESP transition, so they
    // are visible for exactly the single RESP cycle.
    always_comb begin
        state_nxt   = state;
        winner_nxt  = winner;
        rr_nxt      = rr_favor_d;
        cnt_nxt     = cnt;
        mem_req_nxt = mem_req;
        addr_nxt    = mem_addr;
        wdata_nxt   = mem_wdata;
        we_nxt      = mem_we;
        i_rdata_nxt = i_rdata;
        d_rdata_nxt = d_rdata;
        i_ack_nxt   = 1'b0;
        d_ack_nxt   = 1'b0;
        l_ack_nxt   = 1'b0;
        bus_err_nxt = 1'b0;

        case (state)
            ST_IDLE: begin
                if (pick_valid) begin
                    winner_nxt  = pick_id;
                    mem_req_nxt = 1'b1;
                    cnt_nxt     = 8'd0;
                    state_nxt   = ST_ACCESS;
                    case (pick_id)
                        ID_L: begin
                            addr_nxt  = l_addr;
                            wdata_nxt = l_wdata;
                            we_nxt    = l_we;
                        end
                        ID_D: begin
                            addr_nxt  = d_addr;
                            wdata_nxt = d_wdata;
                            we_nxt    = d_we;
                            rr_nxt    = 1'b0;
                        end
                        default: begin
                            addr_nxt  = i_addr;
                            wdata_nxt = 32'd0;
                            we_nxt    = 4'd0;
                            rr_nxt    = 1'b1;
                        end
                    endcase
                end
            end

            ST_ACCESS: begin
                // Ready is tested first so a same-cycle timeout never errors.
                if (mem_ready || (cnt == TIMEOUT_CNT)) begin
                    mem_req_nxt = 1'b0;
                    state_nxt   = ST_RESP;
                    i_ack_nxt   = (winner == ID_I);
                    d_ack_nxt   = (winner == ID_D);
                    l_ack_nxt   = (winner == ID_L);
                    if (mem_ready) begin
                        if (winner == ID_I) i_rdata_nxt = mem_rdata;
                        if (winner == ID_D) d_rdata_nxt = mem_rdata;
                    end else begin
                        bus_err_nxt = 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end

            ST_RESP: begin
                state_nxt = ST_IDLE;
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, d_req, l_req;
    logic [31:0] i_addr, d_addr, d_wdata, l_addr, l_wdata;
    logic [3:0]  d_we, l_we;
    logic [31:0] i_rdata, d_rdata;
    logic        i_ack, d_ack, l_ack;
    logic        mem_req;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_we;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        bus_err;

    logic        auto_mode;
    logic        man_ready;
    logic [31:0] man_rdata;

    int n_checks = 0;
    int n_errors = 0;

    // Zero-wait memory returns the inverted address; manual mode is driven directly.
    assign mem_ready = auto_mode ? mem_req : man_ready;
    assign mem_rdata = auto_mode ? ~mem_addr : man_rdata;

    always #5 clk = ~clk;

    mem_arbiter #(.TIMEOUT(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_rdata   (i_rdata),
        .i_ack     (i_ack),
        .d_req     (d_req),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_we      (d_we),
        .d_rdata   (d_rdata),
        .d_ack     (d_ack),
        .l_req     (l_req),
        .l_addr    (l_addr),
        .l_wdata   (l_wdata),
        .l_we      (l_we),
        .l_ack     (l_ack),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .bus_err   (bus_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    function automatic logic [31:0] acks();
        return {29'd0, l_ack, i_ack, d_ack};
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        i_req = 1'b0; d_req = 1'b0; l_req = 1'b0;
        auto_mode = 1'b1; man_ready = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    logic [2:0] exp_ack;

    initial begin
        i_addr = 32'd0; d_addr = 32'd0; d_wdata = 32'd0; d_we = 4'd0;
        l_addr = 32'd0; l_wdata = 32'd0; l_we = 4'd0; man_rdata = 32'd0;
        do_reset();
        reset = 1'b1;
        step();
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_mem_we", {28'd0, mem_we}, 32'd0);
        check("rst_acks", acks(), 32'd0);
        check("rst_bus_err", {31'd0, bus_err}, 32'd0);
        check("rst_i_rdata", i_rdata, 32'd0);
        check("rst_d_rdata", d_rdata, 32'd0);
        reset = 1'b0;

        // Single fetch with memory ready two cycles after mem_req.
        auto_mode = 1'b0;
        i_req = 1'b1; i_addr = 32'h100;
        step();
        check("fetch_mem_req", {31'd0, mem_req}, 32'd1);
        check("fetch_mem_addr", mem_addr, 32'h100);
        check("fetch_mem_we", {28'd0, mem_we}, 32'd0);
        check("fetch_mem_wdata", mem_wdata, 32'd0);
        step();
        check("fetch_no_ack_yet", acks(), 32'd0);
        man_ready = 1'b1; man_rdata = 32'h00500093;
        step();
        check("fetch_ack", acks(), 32'b010);
        check("fetch_rdata", i_rdata, 32'h00500093);
        check("fetch_mem_req_low", {31'd0, mem_req}, 32'd0);
        i_req = 1'b0; man_ready = 1'b0;
        step();
        check("fetch_ack_drop", acks(), 32'd0);
        check("fetch_rdata_hold", i_rdata, 32'h00500093);

        // I/D contention from reset with zero-wait memory.
        do_reset();
        i_addr = 32'h200; d_addr = 32'h300; d_we = 4'd0;
        i_req = 1'b1; d_req = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            exp_ack = 3'b000;
            if (k % 3 == 2) exp_ack = ((k / 3) % 2 == 0) ? 3'b010 : 3'b001;
            check($sformatf("rr_ack_k%0d", k), acks(), {29'd0, exp_ack});
            if (k % 3 == 1)
                check($sformatf("rr_addr_k%0d", k), mem_addr,
                      ((k / 3) % 2 == 0) ? 32'h200 : 32'h300);
        end
        i_req = 1'b0; d_req = 1'b0;
        check("rr_i_rdata", i_rdata, 32'hFFFFFDFF);
        check("rr_d_rdata", d_rdata, 32'hFFFFFCFF);

        // Loader priority over a simultaneous I/D pair.
        do_reset();
        i_addr = 32'h280; d_addr = 32'h380;
        l_addr = 32'h40; l_we = 4'hF; l_wdata = 32'hCAFEF00D;
        l_req = 1'b1; i_req = 1'b1; d_req = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            exp_ack = (k == 2) ? 3'b100 : (k == 5) ? 3'b010 : (k == 8) ? 3'b001 : 3'b000;
            check($sformatf("ld_ack_k%0d", k), acks(), {29'd0, exp_ack});
            if (k == 1) begin
                check("ld_addr", mem_addr, 32'h40);
                check("ld_we", {28'd0, mem_we}, 32'hF);
                check("ld_wdata", mem_wdata, 32'hCAFEF00D);
            end
            if (k == 4) check("ld_then_i_addr", mem_addr, 32'h280);
            if (k == 7) check("ld_then_d_addr", mem_addr, 32'h380);
            if (k == 2) l_req = 1'b0;
            if (k == 5) i_req = 1'b0;
        end
        d_req = 1'b0;
        step();

        // Timeout: no ready at all, TIMEOUT=4.
        auto_mode = 1'b0; man_ready = 1'b0; man_rdata = 32'h12345678;
        d_req = 1'b1; d_addr = 32'h500;
        for (int k = 1; k <= 6; k++) begin
            step();
            check($sformatf("to_d_ack_k%0d", k), {31'd0, d_ack}, {31'd0, k == 6});
            check($sformatf("to_err_k%0d", k), {31'd0, bus_err}, {31'd0, k == 6});
            check($sformatf("to_mem_req_k%0d", k), {31'd0, mem_req}, {31'd0, k <= 5});
        end
        check("to_d_rdata_kept", d_rdata, 32'hFFFFFC7F);
        d_req = 1'b0;
        step();

        // Ready in the fourth ACCESS cycle: normal completion.
        d_req = 1'b1;
        for (int k = 1; k <= 4; k++) step();
        man_ready = 1'b1; man_rdata = 32'h0BADF00D;
        step();
        check("rdy4_d_ack", {31'd0, d_ack}, 32'd1);
        check("rdy4_no_err", {31'd0, bus_err}, 32'd0);
        check("rdy4_d_rdata", d_rdata, 32'h0BADF00D);
        man_ready = 1'b0; d_req = 1'b0;
        step();

        // Ready in the same cycle the counter hits TIMEOUT: ready wins.
        d_req = 1'b1;
        for (int k = 1; k <= 5; k++) step();
        check("rdy5_not_done", {31'd0, d_ack}, 32'd0);
        man_ready = 1'b1; man_rdata = 32'h600DCAFE;
        step();
        check("rdy5_d_ack", {31'd0, d_ack}, 32'd1);
        check("rdy5_no_err", {31'd0, bus_err}, 32'd0);
        check("rdy5_d_rdata", d_rdata, 32'h600DCAFE);
        man_ready = 1'b0; d_req = 1'b0;
        step();

        // Reset while in ACCESS, then the held fetch is served normally.
        i_req = 1'b1; i_addr = 32'h600;
        step();
        check("rmid_access", {31'd0, mem_req}, 32'd1);
        step();
        reset = 1'b1;
        step();
        check("rmid_mem_req", {31'd0, mem_req}, 32'd0);
        check("rmid_acks", acks(), 32'd0);
        check("rmid_err", {31'd0, bus_err}, 32'd0);
        reset = 1'b0; auto_mode = 1'b1;
        step();
        check("rmid_regrant_addr", mem_addr, 32'h600);
        check("rmid_regrant_acks", acks(), 32'd0);
        step();
        check("rmid_i_ack", acks(), 32'b010);
        check("rmid_i_rdata", i_rdata, 32'hFFFFF9FF);
        i_req = 1'b0;
        step();

        // Spurious mem_ready while idle.
        auto_mode = 1'b0; man_ready = 1'b1; man_rdata = 32'hDEADBEEF;
        for (int k = 1; k <= 3; k++) begin
            step();
            check($sformatf("spur_acks_k%0d", k), acks(), 32'd0);
            check($sformatf("spur_mem_req_k%0d", k), {31'd0, mem_req}, 32'd0);
        end
        check("spur_i_rdata", i_rdata, 32'hFFFFF9FF);
        man_ready = 1'b0;
        i_req = 1'b1; i_addr = 32'h700;
        step();
        check("spur_then_grant", {31'd0, mem_req}, 32'd1);
        check("spur_then_addr", mem_addr, 32'h700);
        i_req = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255: max ACCESS cycles before abort (1..255).
REQ-002 clk  in  1  clock; all logic on rising edge.
REQ-003 reset  in  1  synchronous, active-high.
REQ-004 i_req / i_addr  in  1 / 32  instruction-fetch read request and byte address.
REQ-005 i_rdata / i_ack  out  32 / 1  fetch read data and completion pulse.
REQ-006 d_req / d_addr / d_wdata / d_we  in  1 / 32 / 32 / 4  data-port request, address, write data, byte enables (0000 = read).
REQ-007 d_rdata / d_ack  out  32 / 1  data read data and completion pulse.
REQ-008 l_req / l_addr / l_wdata / l_we  in  1 / 32 / 32 / 4  program-loader write port.
REQ-009 l_ack  out  1  loader completion pulse.
REQ-010 mem_req / mem_addr / mem_wdata / mem_we  out  1 / 32 / 32 / 4  shared memory request, all registered.
REQ-011 mem_rdata / mem_ready  in  32 / 1  memory read data and access-done strobe.
REQ-012 bus_err  out  1  one-cycle pulse on timeout abort.

Function
REQ-013 FSM states: IDLE, ACCESS, RESP.
REQ-014 IDLE: if any req high, latch winner ID and its addr/wdata/we into mem_* registers, set mem_req=1, go ACCESS; else stay.
REQ-015 Priority: l_req always wins; between i_req and d_req, round-robin with one last-grant bit, initial favour to I.
REQ-016 Round-robin bit updates only on I or D grants; L grants leave it unchanged.
REQ-017 I grants drive mem_we=0000 and mem_wdata=0.
REQ-018 ACCESS: mem_* held stable; cycle counter increments each cycle.
REQ-019 ACCESS, mem_ready=1: capture mem_rdata into winner's rdata register (I or D only), mem_req=0, go RESP.
REQ-020 ACCESS, counter reaches TIMEOUT without mem_ready: mem_req=0, set err flag, go RESP; rdata registers unchanged.
REQ-021 mem_ready and timeout in same cycle: ready wins, no error.
REQ-022 RESP: winner's ack high exactly one cycle; bus_err high same cycle if err flag set; go IDLE unconditionally.
REQ-023 Latency: req seen in IDLE at edge n -> mem_req high after edge n; mem_ready at edge m -> ack high after edge m; min 3 cycles req-to-ack.
REQ-024 Requesters hold req and payload stable until ack; arbiter ignores payload changes after grant.
REQ-025 i_rdata/d_rdata hold last captured value until next completion on that port.
REQ-026 mem_ready outside ACCESS ignored.
REQ-027 Only one ack high per cycle; no ack without a prior grant.

Reset
REQ-028 Reset: state IDLE, mem_req=0, mem_addr/mem_wdata=0, mem_we=0000, all acks=0, bus_err=0, i_rdata/d_rdata=0, counter=0, RR bit favours I.
REQ-029 Reset mid-ACCESS/RESP aborts the transfer: no ack or bus_err issued, mem_req low after the reset edge.

Structure
REQ-030 Shared package mem_arb_pkg holds state enum, port IDs (ID_I=0, ID_D=1, ID_L=2, 2 bits), default TIMEOUT.
REQ-031 Combinational winner selection lives in one sub-module mem_arb_pick (inputs: three reqs, RR bit; outputs: valid, ID).

Verification
REQ-032 Single fetch: i_req, i_addr=0x100, mem_ready 2 cycles after mem_req with mem_rdata=0x00500093 -> mem_addr=0x100, mem_we=0000, i_ack one cycle, i_rdata=0x00500093.
REQ-033 Contention: i_req and d_req held continuously from reset, zero-wait memory -> grants alternate I,D,I,D; each ack spaced 3 cycles.
REQ-034 Loader priority: l_req, i_req, d_req together, l_addr=0x40, l_we=1111, l_wdata=0xCAFEF00D -> first mem access is loader write with those values; l_ack first; RR order of I/D unaffected.
REQ-035 Timeout: d_req, TIMEOUT=4, mem_ready never -> d_ack and bus_err together 5 cycles after mem_req rises, d_rdata unchanged; mem_ready on cycle 4 instead -> no bus_err.
REQ-036 Reset mid-op: reset asserted during ACCESS -> no ack, mem_req=0 next cycle, subsequent i_req served normally.
REQ-037 Spurious mem_ready while IDLE with no reqs -> no ack, no state change.
